// File: rtl/time_uart_formatter.sv
// Timestamp formatter: snapshots minutes/seconds on each seconds change and streams
// "MM:SS" (optionally CR LF) as ASCII bytes over a valid/ready interface.
module time_uart_formatter #(
   parameter int SEND_CRLF = 1,
   parameter int DROP_W    = 8
) (
   input  logic              InClk,
   input  logic              InReset,
   input  logic              InEnable,
   input  logic [5:0]        InSecond,
   input  logic [5:0]        InMinute,
   input  logic              InTxReady,
   output logic [7:0]        OutTxData,
   output logic              OutTxValid,
   output logic              OutBusy,
   output logic [DROP_W-1:0] OutDropCnt
);

   localparam logic [2:0] LAST_IDX = (SEND_CRLF != 0) ? 3'd6 : 3'd4;

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t            state_q, state_d;
   logic [5:0]        prev_sec_q;
   logic [5:0]        min_q, min_d;
   logic [5:0]        sec_q, sec_d;
   logic [7:0]        frame_q [7];
   logic [7:0]        frame_d [7];
   logic [2:0]        idx_q, idx_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              trigger;
   logic              xfer;
   logic              last;
   logic [15:0]       min_ascii;
   logic [15:0]       sec_ascii;

   // Saturate to 59, then peel off tens by repeated subtraction; returns {tens, units} as ASCII.
   function automatic logic [15:0] to_ascii(input logic [5:0] v);
      logic [5:0] r;
      logic [3:0] t;
      r = (v > 6'd59) ? 6'd59 : v;
      t = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
         end
      end
      return {8'h30 + {4'h0, t}, 8'h30 + {4'h0, r[3:0]}};
   endfunction

   assign trigger   = (InSecond != prev_sec_q);
   assign xfer      = (state_q == SEND) && InTxReady;
   assign last      = (idx_q == LAST_IDX);
   assign min_ascii = to_ascii(min_q);
   assign sec_ascii = to_ascii(sec_q);

   always_ff @(posedge InClk or negedge InReset) begin
      if (!InReset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (trigger && InEnable) state_d = LOAD;
         LOAD:    state_d = SEND;
         SEND:    if (xfer && last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      OutTxValid = (state_q == SEND);
      OutBusy    = (state_q != IDLE);
      OutTxData  = (state_q == SEND) ? frame_q[idx_q] : '0;
      OutDropCnt = drop_q;
   end

   always_comb begin
      min_d   = min_q;
      sec_d   = sec_q;
      frame_d = frame_q;
      idx_d   = idx_q;
      drop_d  = drop_q;
      if (state_q == IDLE && trigger && InEnable) begin
         min_d = InMinute;
         sec_d = InSecond;
      end
      // A trigger landing on the final transfer edge still counts as busy.
      if (state_q != IDLE && trigger && drop_q != '1) begin
         drop_d = drop_q + 1'b1;
      end
      if (state_q == LOAD) begin
         frame_d[0] = min_ascii[15:8];
         frame_d[1] = min_ascii[7:0];
         frame_d[2] = 8'h3A;
         frame_d[3] = sec_ascii[15:8];
         frame_d[4] = sec_ascii[7:0];
         frame_d[5] = 8'h0D;
         frame_d[6] = 8'h0A;
         idx_d      = '0;
      end
      if (xfer && !last) begin
         idx_d = idx_q + 3'd1;
      end
   end

   always_ff @(posedge InClk or negedge InReset) begin
      if (!InReset) begin
         prev_sec_q <= '0;
         min_q      <= '0;
         sec_q      <= '0;
         frame_q    <= '{default: '0};
         idx_q      <= '0;
         drop_q     <= '0;
      end else begin
         prev_sec_q <= InSecond;
         min_q      <= min_d;
         sec_q      <= sec_d;
         frame_q    <= frame_d;
         idx_q      <= idx_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_time_uart_formatter.sv
// Bench for time_uart_formatter: CRLF and no-CRLF instances share stimulus; a frame-level
// model predicts busy/valid/drop count and pushes expected bytes to per-instance scoreboards.
module tb_time_uart_formatter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       rdy = 1'b0;
   logic [5:0] sec = '0;
   logic [5:0] mn = '0;

   logic [7:0] d0, d1;
   logic       v0, v1, b0, b1;
   logic [7:0] dc0, dc1;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb0[$];
   logic [7:0] sb1[$];

   int   m_ld   [2];
   int   m_rem  [2];
   int   m_drop [2];
   logic [5:0] m_prev;

   time_uart_formatter #(.SEND_CRLF(1), .DROP_W(8)) u0 (
      .InClk(clk), .InReset(rst_n), .InEnable(en), .InSecond(sec), .InMinute(mn),
      .InTxReady(rdy), .OutTxData(d0), .OutTxValid(v0), .OutBusy(b0), .OutDropCnt(dc0));

   time_uart_formatter #(.SEND_CRLF(0), .DROP_W(8)) u1 (
      .InClk(clk), .InReset(rst_n), .InEnable(en), .InSecond(sec), .InMinute(mn),
      .InTxReady(rdy), .OutTxData(d1), .OutTxValid(v1), .OutBusy(b1), .OutDropCnt(dc1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat59(input int v);
      return (v > 59) ? 59 : v;
   endfunction

   task automatic push_frame(input int k, input int m, input int s);
      logic [7:0] fr[$];
      fr = '{8'(48 + sat59(m) / 10), 8'(48 + sat59(m) % 10), 8'h3A,
             8'(48 + sat59(s) / 10), 8'(48 + sat59(s) % 10)};
      if (k == 0) begin
         fr.push_back(8'h0D);
         fr.push_back(8'h0A);
      end
      foreach (fr[i]) begin
         if (k == 0) sb0.push_back(fr[i]);
         else        sb1.push_back(fr[i]);
      end
   endtask

   // Reference model: checks current status, then advances to the state after the next posedge.
   always @(negedge clk) begin : model
      if (!rst_n) begin
         chk("rst_valid0", int'(v0), 0);
         chk("rst_busy0",  int'(b0), 0);
         chk("rst_drop0",  int'(dc0), 0);
         chk("rst_data0",  int'(d0), 0);
         chk("rst_valid1", int'(v1), 0);
         chk("rst_drop1",  int'(dc1), 0);
         for (int k = 0; k < 2; k++) begin
            m_ld[k] = 0; m_rem[k] = 0; m_drop[k] = 0;
         end
         sb0.delete();
         sb1.delete();
         m_prev = '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            int  len;
            bit  busy;
            bit  trig;
            len  = (k == 0) ? 7 : 5;
            busy = (m_ld[k] != 0) || (m_rem[k] > 0);
            trig = (sec != m_prev);
            chk(k == 0 ? "busy0"  : "busy1",  int'(k == 0 ? b0 : b1), int'(busy));
            chk(k == 0 ? "valid0" : "valid1", int'(k == 0 ? v0 : v1), int'(m_rem[k] > 0));
            chk(k == 0 ? "drop0"  : "drop1",  int'(k == 0 ? dc0 : dc1), m_drop[k]);
            if (m_ld[k] != 0) begin
               m_rem[k] = len;
               m_ld[k]  = 0;
            end else if (m_rem[k] > 0 && rdy) begin
               m_rem[k]--;
            end
            if (trig) begin
               if (busy) begin
                  if (m_drop[k] < 255) m_drop[k]++;
               end else if (en) begin
                  m_ld[k] = 1;
                  push_frame(k, int'(mn), int'(sec));
               end
            end
         end
         m_prev = sec;
      end
   end

   always @(negedge clk) begin : monitor
      if (rst_n) begin
         if (v0 && rdy) begin
            if (sb0.size() == 0) begin
               total++; bad++;
               $display("FAIL byte0 actual=%0h required=none (unexpected byte) at %0t", d0, $time);
            end else begin
               chk("byte0", int'(d0), int'(sb0.pop_front()));
            end
         end
         if (v1 && rdy) begin
            if (sb1.size() == 0) begin
               total++; bad++;
               $display("FAIL byte1 actual=%0h required=none (unexpected byte) at %0t", d1, $time);
            end else begin
               chk("byte1", int'(d1), int'(sb1.pop_front()));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic next_sec();
      if (sec >= 6'd59) begin
         sec = '0;
         mn  = (mn >= 6'd59) ? 6'd0 : mn + 6'd1;
      end else begin
         sec = sec + 6'd1;
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; rdy = 1'b1; sec = '0; mn = '0;
      tick(3);
      rst_n = 1'b1;
      tick(3);
      // "00:01" with ready held high
      sec = 6'd1;
      tick(12);
      // "59:58" then "59:59" under toggling ready
      mn = 6'd59; sec = 6'd58;
      tick(12);
      sec = 6'd59;
      for (int i = 0; i < 20; i++) begin
         rdy = ~rdy;
         tick(1);
      end
      rdy = 1'b1;
      tick(6);
      // coherent snapshot across minute rollover
      mn = 6'd12;
      tick(2);
      mn = 6'd13; sec = 6'd0;
      tick(12);
      // stalled frame plus three dropped triggers
      rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_sec();
         tick(3);
      end
      rdy = 1'b1;
      tick(12);
      // drop counter saturation
      rdy = 1'b0;
      for (int i = 0; i < 300; i++) begin
         next_sec();
         tick(1);
      end
      chk("drop_sat", int'(dc0), 255);
      rdy = 1'b1;
      tick(12);
      // enable low: change ignored
      en = 1'b0;
      next_sec();
      tick(10);
      en = 1'b1;
      tick(2);
      // reset after two bytes of a frame
      next_sec();
      tick(4);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(10);
      // randomized traffic, including out-of-range inputs
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            if ($urandom_range(7, 0) == 0) sec = 6'($urandom_range(63, 0));
            else                           next_sec();
         end
         if ($urandom_range(31, 0) == 0) mn = 6'($urandom_range(63, 0));
         rdy   = ($urandom_range(2, 0) != 0);
         en    = ($urandom_range(15, 0) != 0);
         rst_n = ($urandom_range(499, 0) != 0);
         tick(1);
      end
      rst_n = 1'b1; rdy = 1'b1; en = 1'b0;
      tick(20);
      chk("sb0_empty", sb0.size(), 0);
      chk("sb1_empty", sb1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
